// File: rtl/riscv_isa_pkg.sv
// RV32M/RV64M shared definitions: divide opcode enum and M-ext decode helpers.
// Imported by the divide sequencer and the decoder that issues to it.
package riscv_isa_pkg;

  // Values match funct3[1:0] of the M-ext divide encodings.
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OP_32 = 7'b0111011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  function automatic logic is_div_insn(input logic [31:0] insn);
    return ((insn[6:0] == OPC_OP) || (insn[6:0] == OPC_OP_32)) &&
           (insn[31:25] == F7_MULDIV) && insn[14];
  endfunction

  function automatic div_op_t div_op_of(input logic [2:0] funct3);
    return div_op_t'(funct3[1:0]);
  endfunction

endpackage

// File: rtl/r5p_div_step.sv
// One restoring divide step: {rem,q[msb]} - |b|, keep or restore, shift in q bit.
// Ports: rem_i/quo_i/dvs_i current remainder, quotient shifter, divisor; rem_o/quo_o next.
module r5p_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN+1:0] diff;

  // Top bit of diff is the borrow; restored value fits XLEN bits since it is < |b|.
  always_comb begin
    diff  = {1'b0, rem_i, quo_i[XLEN-1]} - {2'b00, dvs_i};
    rem_o = diff[XLEN+1] ? {rem_i[XLEN-2:0], quo_i[XLEN-1]}
                         : diff[XLEN-1:0];
    quo_o = {quo_i[XLEN-2:0], ~diff[XLEN+1]};
  end

endmodule

// File: rtl/r5p_div_seq.sv
// Iterative DIV/DIVU/REM/REMU (+W) sequencer, one quotient bit per clk, req/rsp handshake.
// Ports: clk, rst (sync, low), kill, req_vld/rdy/op/wrd, rs1, rs2, rsp_vld/rdy/dat.
module r5p_div_seq
  import riscv_isa_pkg::*;
#(
  parameter int   XLEN    = 32,
  parameter logic CFG_DZF = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            req_vld,
  output logic            req_rdy,
  input  div_op_t         req_op,
  input  logic            req_wrd,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [XLEN-1:0] rsp_dat
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef logic [1:0] div_state_t;
  localparam div_state_t S_IDLE = 2'd0;
  localparam div_state_t S_CALC = 2'd1;
  localparam div_state_t S_FIX  = 2'd2;
  localparam div_state_t S_DONE = 2'd3;

  div_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            isrem_q, isrem_d;
  logic            wrd_q, wrd_d;

  logic [XLEN-1:0] step_rem, step_quo;
  logic            wrd, sgn, is_rem;
  logic            a_neg, b_neg, b_zero;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs;
  logic [XLEN-1:0] q_fix, r_fix;

  function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v,
                                            input logic s);
    return s ? sx32(v) : XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] v,
                                          input logic w);
    return w ? sx32(v[31:0]) : v;
  endfunction

  r5p_div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Accept-cycle operand conditioning. |MIN| lands on 2^(XLEN-1) unsigned.
  always_comb begin
    wrd    = (XLEN == 64) && req_wrd;
    sgn    = (req_op == DIV_OP_DIV) || (req_op == DIV_OP_REM);
    is_rem = (req_op == DIV_OP_REM) || (req_op == DIV_OP_REMU);
    a_ext  = wrd ? ext32(rs1[31:0], sgn) : rs1;
    b_ext  = wrd ? ext32(rs2[31:0], sgn) : rs2;
    a_neg  = sgn && a_ext[XLEN-1];
    b_neg  = sgn && b_ext[XLEN-1];
    a_abs  = a_neg ? -a_ext : a_ext;
    b_abs  = b_neg ? -b_ext : b_ext;
    b_zero = (b_ext == '0);
  end

  always_comb begin
    q_fix = qneg_q ? -quo_q : quo_q;
    r_fix = rneg_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    isrem_d = isrem_q;
    wrd_d   = wrd_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_vld && !kill) begin
          // Word dividend is left-aligned so 32 steps consume it.
          rem_d   = '0;
          quo_d   = wrd ? a_abs << (XLEN - 32) : a_abs;
          dvs_d   = b_abs;
          qneg_d  = (a_neg ^ b_neg) && !b_zero;
          rneg_d  = a_neg;
          isrem_d = is_rem;
          wrd_d   = wrd;
          cnt_d   = wrd ? CW'(31) : CW'(XLEN - 1);
          if (CFG_DZF && b_zero) begin
            res_d   = fin(is_rem ? a_ext : '1, wrd);
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        res_d   = fin(isrem_q ? r_fix : q_fix, wrd_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      isrem_q <= 1'b0;
      wrd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      isrem_q <= isrem_d;
      wrd_q   <= wrd_d;
    end
  end

  assign req_rdy = (state_q == S_IDLE);
  assign rsp_vld = (state_q == S_DONE);
  assign rsp_dat = res_q;

endmodule
